n64_input_sync: RTL and testbench

Front-end conditioning stage that sits directly upstream of `n64_top`. It takes the raw, asynchronous N64 console pins (reset, NMI, PI strobes, SI and CIC clocks) and synchronises them into `clk`. It glitch-filters the reset/NMI lines, produces single-cycle edge pulses, and tracks the console reset sequence. The PI, SI and CIC units consume its outputs instead of the raw pins.

---
 rtl/n64_input_sync.sv | 196 +++++++++++++++++++
 tb/tb_n64_input_sync.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_input_sync.sv
// n64_input_sync: synchronises raw N64 console pins into clk, produces
// edge pulses, glitch-filters reset/NMI and tracks the console reset state.
module n64_input_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4,
    parameter logic [15:0] NMI_TIMEOUT = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       n64_reset,
    input  logic       n64_nmi,
    input  logic       n64_pi_alel,
    input  logic       n64_pi_aleh,
    input  logic       n64_pi_read,
    input  logic       n64_pi_write,
    input  logic       n64_si_clk,
    input  logic       n64_cic_clk,
    output logic       alel_s,
    output logic       aleh_s,
    output logic       read_s,
    output logic       write_s,
    output logic       si_clk_s,
    output logic       cic_clk_s,
    output logic       alel_fall,
    output logic       aleh_fall,
    output logic       read_fall,
    output logic       read_rise,
    output logic       write_fall,
    output logic       write_rise,
    output logic       si_clk_rise,
    output logic       cic_clk_rise,
    output logic       reset_f,
    output logic       nmi_f,
    output logic [1:0] reset_state,
    output logic       soft_reset_pulse,
    output logic       hard_reset_pulse
);

    localparam int unsigned NB = 8;
    localparam int unsigned CW = $clog2(FILTER_LEN + 1);
    localparam int unsigned WW = $clog2(SYNC_STAGES + 2);
    localparam logic [WW-1:0] WMAX = WW'(SYNC_STAGES + 1);
    localparam logic [CW-1:0] FMAX = CW'(FILTER_LEN - 1);
    localparam logic [15:0] TMAX = NMI_TIMEOUT - 16'd1;
    // bit order: alel, aleh, read, write, si, cic, reset, nmi
    localparam logic [NB-1:0] IDLE = 8'b1011_1100;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_NMI   = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][NB-1:0] chain_q;
    logic [NB-1:0] raw;
    logic [NB-1:0] sync;
    logic [5:0]    prev_q;
    logic [7:0]    pulse_q;
    logic [7:0]    pulse_d;
    logic [WW-1:0] warm_q;
    logic          en;
    logic [1:0]    filt_q;
    logic [1:0]    filt_d;
    logic [CW-1:0] fcnt_q [2];
    logic [CW-1:0] fcnt_d [2];
    state_t        state_q;
    logic [15:0]   tcnt_q;
    logic          soft_q;
    logic          hard_q;

    assign raw = {n64_nmi, n64_reset, n64_cic_clk, n64_si_clk,
                  n64_pi_write, n64_pi_read, n64_pi_aleh, n64_pi_alel};
    assign sync = chain_q[SYNC_STAGES-1];
    assign en = (warm_q == WMAX);

    // synchroniser chains for every pin, reset to idle levels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) chain_q <= {SYNC_STAGES{IDLE}};
        else       chain_q <= {chain_q[SYNC_STAGES-2:0], raw};
    end

    // pulse next-state: edge of the synchronised level, gated by warm-up
    always_comb begin
        pulse_d    = '0;
        pulse_d[0] = prev_q[0] & ~sync[0];
        pulse_d[1] = prev_q[1] & ~sync[1];
        pulse_d[2] = prev_q[2] & ~sync[2];
        pulse_d[3] = ~prev_q[2] & sync[2];
        pulse_d[4] = prev_q[3] & ~sync[3];
        pulse_d[5] = ~prev_q[3] & sync[3];
        pulse_d[6] = ~prev_q[4] & sync[4];
        pulse_d[7] = ~prev_q[5] & sync[5];
        if (!en) pulse_d = '0;
    end

    // edge delay, registered pulses and the startup warm-up counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q  <= IDLE[5:0];
            pulse_q <= '0;
            warm_q  <= '0;
        end else begin
            prev_q  <= sync[5:0];
            pulse_q <= pulse_d;
            if (!en) warm_q <= warm_q + 1'b1;
        end
    end

    // reset/NMI filter: value follows input only after a stable run
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            fcnt_d[i] = '0;
            if (sync[6+i] != filt_q[i]) begin
                if (fcnt_q[i] >= FMAX) filt_d[i] = sync[6+i];
                else                   fcnt_d[i] = fcnt_q[i] + 1'b1;
            end
        end
    end

    // filter state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q    <= 2'b10;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
        end else begin
            filt_q    <= filt_d;
            fcnt_q[0] <= fcnt_d[0];
            fcnt_q[1] <= fcnt_d[1];
        end
    end

    // console reset state machine with registered transition pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RESET;
            tcnt_q  <= '0;
            soft_q  <= 1'b0;
            hard_q  <= 1'b0;
        end else begin
            soft_q <= 1'b0;
            hard_q <= 1'b0;
            unique case (state_q)
                ST_RESET: begin
                    if (filt_q[0]) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (!filt_q[0]) begin
                        state_q <= ST_RESET;
                        hard_q  <= 1'b1;
                    end else if (!filt_q[1]) begin
                        state_q <= ST_NMI;
                        soft_q  <= 1'b1;
                        tcnt_q  <= '0;
                    end
                end
                ST_NMI: begin
                    if (!filt_q[0]) begin
                        state_q <= ST_RESET;
                        hard_q  <= 1'b1;
                    end else if (tcnt_q == TMAX) begin
                        if (filt_q[1]) begin
                            state_q <= ST_RUN;
                            tcnt_q  <= '0;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + 16'd1;
                    end
                end
                default: state_q <= ST_RESET;
            endcase
        end
    end

    assign alel_s           = sync[0];
    assign aleh_s           = sync[1];
    assign read_s           = sync[2];
    assign write_s          = sync[3];
    assign si_clk_s         = sync[4];
    assign cic_clk_s        = sync[5];
    assign alel_fall        = pulse_q[0];
    assign aleh_fall        = pulse_q[1];
    assign read_fall        = pulse_q[2];
    assign read_rise        = pulse_q[3];
    assign write_fall       = pulse_q[4];
    assign write_rise       = pulse_q[5];
    assign si_clk_rise      = pulse_q[6];
    assign cic_clk_rise     = pulse_q[7];
    assign reset_f          = filt_q[0];
    assign nmi_f            = filt_q[1];
    assign reset_state      = state_q;
    assign soft_reset_pulse = soft_q;
    assign hard_reset_pulse = hard_q;

endmodule

// File: tb/tb_n64_input_sync.sv
// Testbench for n64_input_sync: directed vectors, SYNC_STAGES=2,
// FILTER_LEN=4, NMI_TIMEOUT=100.
module tb_n64_input_sync;

    logic clk, reset;
    logic n64_reset, n64_nmi;
    logic n64_pi_alel, n64_pi_aleh, n64_pi_read, n64_pi_write;
    logic n64_si_clk, n64_cic_clk;
    logic alel_s, aleh_s, read_s, write_s, si_clk_s, cic_clk_s;
    logic alel_fall, aleh_fall, read_fall, read_rise;
    logic write_fall, write_rise, si_clk_rise, cic_clk_rise;
    logic reset_f, nmi_f;
    logic [1:0] reset_state;
    logic soft_reset_pulse, hard_reset_pulse;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_NMI   = 2'd2;
    localparam logic [19:0] RST_VALS = 20'b001111_00000000_01_00_00;

    typedef struct packed {
        logic       alel;
        logic       read;
        logic       write;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [20];

    n64_input_sync #(
        .SYNC_STAGES(2),
        .FILTER_LEN(4),
        .NMI_TIMEOUT(16'd100)
    ) dut (
        .clk(clk), .reset(reset),
        .n64_reset(n64_reset), .n64_nmi(n64_nmi),
        .n64_pi_alel(n64_pi_alel), .n64_pi_aleh(n64_pi_aleh),
        .n64_pi_read(n64_pi_read), .n64_pi_write(n64_pi_write),
        .n64_si_clk(n64_si_clk), .n64_cic_clk(n64_cic_clk),
        .alel_s(alel_s), .aleh_s(aleh_s), .read_s(read_s),
        .write_s(write_s), .si_clk_s(si_clk_s), .cic_clk_s(cic_clk_s),
        .alel_fall(alel_fall), .aleh_fall(aleh_fall),
        .read_fall(read_fall), .read_rise(read_rise),
        .write_fall(write_fall), .write_rise(write_rise),
        .si_clk_rise(si_clk_rise), .cic_clk_rise(cic_clk_rise),
        .reset_f(reset_f), .nmi_f(nmi_f), .reset_state(reset_state),
        .soft_reset_pulse(soft_reset_pulse),
        .hard_reset_pulse(hard_reset_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    function automatic logic [7:0] pulses();
        return {alel_fall, aleh_fall, read_fall, read_rise,
                write_fall, write_rise, si_clk_rise, cic_clk_rise};
    endfunction

    function automatic logic [19:0] pack_all();
        return {alel_s, aleh_s, read_s, write_s, si_clk_s, cic_clk_s,
                pulses(), reset_f, nmi_f, reset_state,
                soft_reset_pulse, hard_reset_pulse};
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic a, input logic r,
                                input logic w, input logic [7:0] e);
        vec_t v;
        v.alel = a; v.read = r; v.write = w; v.exp = e;
        return v;
    endfunction

    initial begin
        tbl[0]  = mk(0, 0, 1, 8'b011_00000);
        tbl[1]  = mk(0, 0, 1, 8'b001_00000);
        tbl[2]  = mk(0, 0, 1, 8'b001_01000);
        tbl[3]  = mk(0, 0, 1, 8'b001_00000);
        tbl[4]  = mk(0, 0, 1, 8'b001_00000);
        tbl[5]  = mk(0, 1, 1, 8'b001_00000);
        tbl[6]  = mk(0, 1, 1, 8'b011_00000);
        tbl[7]  = mk(0, 1, 1, 8'b011_00100);
        tbl[8]  = mk(0, 1, 1, 8'b011_00000);
        tbl[9]  = mk(0, 1, 1, 8'b011_00000);
        tbl[10] = mk(1, 1, 0, 8'b011_00000);
        tbl[11] = mk(1, 1, 0, 8'b110_00000);
        tbl[12] = mk(0, 1, 1, 8'b110_00010);
        tbl[13] = mk(0, 1, 1, 8'b011_00000);
        tbl[14] = mk(0, 1, 0, 8'b011_10001);
        tbl[15] = mk(0, 1, 0, 8'b010_00000);
        tbl[16] = mk(0, 1, 1, 8'b010_00010);
        tbl[17] = mk(0, 1, 1, 8'b011_00000);
        tbl[18] = mk(0, 1, 1, 8'b011_00001);
        tbl[19] = mk(0, 1, 1, 8'b011_00000);

        reset = 1'b1;
        n64_reset = 1'b1; n64_nmi = 1'b1;
        n64_pi_alel = 1'b0; n64_pi_aleh = 1'b0;
        n64_pi_read = 1'b1; n64_pi_write = 1'b1;
        n64_si_clk = 1'b1; n64_cic_clk = 1'b1;
        repeat (2) tick();
        check("reset_vals", 32'(pack_all()), 32'(RST_VALS));

        // release with idle pins
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("rel_f_state[%0d]", e),
                  {reset_f, reset_state},
                  {(e >= 6), (e >= 7) ? S_RUN : S_RESET});
            check($sformatf("rel_pulses[%0d]", e), 32'(pulses()), 0);
        end

        // PI strobe vector table
        for (int i = 0; i < 20; i++) begin
            n64_pi_alel  = tbl[i].alel;
            n64_pi_read  = tbl[i].read;
            n64_pi_write = tbl[i].write;
            tick();
            check($sformatf("pi_vec[%0d]", i),
                  {alel_s, read_s, write_s, alel_fall, read_fall,
                   read_rise, write_fall, write_rise}, tbl[i].exp);
        end

        // 3-cycle NMI glitch is rejected
        for (int e = 0; e <= 12; e++) begin
            n64_nmi = (e < 3) ? 1'b0 : 1'b1;
            tick();
            check($sformatf("glitch3[%0d]", e), {nmi_f, reset_state},
                  {1'b1, S_RUN});
        end

        // 4-cycle NMI propagates, then timeout back to RUN
        for (int e = 0; e <= 110; e++) begin
            n64_nmi = (e < 4) ? 1'b0 : 1'b1;
            tick();
            check($sformatf("nmi4_timeout[%0d]", e),
                  {nmi_f, reset_state, soft_reset_pulse, hard_reset_pulse},
                  {!(e >= 5 && e <= 8),
                   (e < 6) ? S_RUN : ((e < 106) ? S_NMI : S_RUN),
                   (e == 6), 1'b0});
        end

        // NMI held low stays in NMI
        for (int e = 0; e < 1000; e++) begin
            n64_nmi = 1'b0;
            tick();
            check($sformatf("nmi_hold[%0d]", e),
                  {nmi_f, reset_state, soft_reset_pulse, hard_reset_pulse},
                  {(e < 5), (e < 6) ? S_RUN : S_NMI, (e == 6), 1'b0});
        end

        // console reset from NMI, then release back to RUN
        for (int e = 0; e <= 20; e++) begin
            n64_reset = (e < 10) ? 1'b0 : 1'b1;
            n64_nmi = 1'b1;
            tick();
            check($sformatf("nmi_to_reset[%0d]", e),
                  {reset_f, nmi_f, reset_state,
                   soft_reset_pulse, hard_reset_pulse},
                  {!(e >= 5 && e <= 14), (e >= 5),
                   (e < 6) ? S_NMI : ((e < 16) ? S_RESET : S_RUN),
                   1'b0, (e == 6)});
        end

        // SI/CIC rise and ALEH fall while entering NMI
        for (int e = 0; e < 10; e++) begin
            n64_nmi = 1'b0; n64_si_clk = 1'b0;
            n64_cic_clk = 1'b0; n64_pi_aleh = 1'b1;
            tick();
        end
        check("enter_nmi", reset_state, S_NMI);
        for (int f = 0; f <= 4; f++) begin
            n64_si_clk = 1'b1; n64_cic_clk = 1'b1; n64_pi_aleh = 1'b0;
            tick();
            check($sformatf("si_cic_aleh[%0d]", f),
                  {si_clk_s, si_clk_rise, cic_clk_rise, aleh_fall},
                  {(f >= 1), (f == 2), (f == 2), (f == 2)});
        end

        // async reset with a pulse in flight
        n64_si_clk = 1'b0; n64_cic_clk = 1'b0;
        repeat (5) tick();
        n64_cic_clk = 1'b1;
        repeat (3) tick();
        check("pre_reset", {si_clk_s, cic_clk_rise, reset_state},
              {1'b0, 1'b1, S_NMI});
        #3 reset = 1'b1;
        #1;
        check("async_reset", 32'(pack_all()), 32'(RST_VALS));

        // guard: edge inside warm-up window is suppressed
        n64_nmi = 1'b1; n64_si_clk = 1'b1;
        n64_cic_clk = 1'b1; n64_pi_read = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("guard_in[%0d]", e), {read_s, read_fall},
                  {(e < 2), 1'b0});
        end
        n64_pi_read = 1'b1;
        repeat (6) tick();

        // guard: first edge after the window is passed
        #3 reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("guard_out[%0d]", e), read_fall, (e == 4));
            if (e == 1) n64_pi_read = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
